// File: rtl/lime_io_pkg.sv
// Shared constants for the lime I/O port: register map, STATUS layout and
// FIFO sizing.
package lime_io_pkg;

  localparam int DATA_W             = 16;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  // Count field must represent 0..16 inclusive.
  localparam int CNT_W              = 5;

  localparam logic [1:0] ADDR_DATA_IN  = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_DATA_OUT = 2'd2;
  localparam logic [1:0] ADDR_RSVD     = 2'd3;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_OUT_VALID = 1;
  localparam int ST_COUNT_LSB = 2;
  localparam int ST_COUNT_MSB = 6;
  localparam int ST_UNDERFLOW = 7;
  localparam int ST_OVERFLOW  = 8;

endpackage

// File: rtl/lime_io_fifo.sv
// Host-to-processor input FIFO; the head word is visible combinationally so
// a pop can be captured into the read register on the same edge.
module lime_io_fifo
  import lime_io_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage carries no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lime_io_port.sv
// Processor-mapped I/O port: input FIFO from the host, a single-word output
// register to the host, and a STATUS register with sticky error flags.
module lime_io_port
  import lime_io_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [1:0]        io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_we,
  input  logic              io_re,
  output logic [DATA_W-1:0] io_rdata,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DATA_W-1:0] main_output,
  output logic              out_valid,
  input  logic              out_ack
);

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  logic              underflow;
  logic              overflow;
  logic [DATA_W-1:0] status_word;

  logic              rd_data_in;
  logic              wr_data_out;
  logic              wr_status;
  logic              out_load;
  logic              underflow_evt;
  logic              overflow_evt;

  assign host_in_ready = !fifo_full && !Reset;
  assign fifo_push     = host_in_valid && host_in_ready;
  assign rd_data_in    = io_re && (io_addr == ADDR_DATA_IN);
  assign fifo_pop      = rd_data_in && !fifo_empty;

  assign wr_data_out   = io_we && (io_addr == ADDR_DATA_OUT);
  assign wr_status     = io_we && (io_addr == ADDR_STATUS);
  // An ack on the same edge frees the register for the new word.
  assign out_load      = wr_data_out && (!out_valid || out_ack);
  assign underflow_evt = rd_data_in && fifo_empty;
  assign overflow_evt  = wr_data_out && out_valid && !out_ack;

  lime_io_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (fifo_push),
    .wdata (host_in_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every bit gets a default first so no latch is inferred.
  always_comb begin
    status_word                             = '0;
    status_word[ST_NONEMPTY]                = !fifo_empty;
    status_word[ST_OUT_VALID]               = out_valid;
    status_word[ST_COUNT_MSB:ST_COUNT_LSB]  = fifo_count;
    status_word[ST_UNDERFLOW]               = underflow;
    status_word[ST_OVERFLOW]                = overflow;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      io_rdata <= '0;
    end else if (io_re) begin
      case (io_addr)
        ADDR_DATA_IN: io_rdata <= fifo_empty ? '0 : fifo_head;
        ADDR_STATUS:  io_rdata <= status_word;
        default:      io_rdata <= '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      main_output <= '0;
      out_valid   <= 1'b0;
    end else if (out_load) begin
      main_output <= io_wdata;
      out_valid   <= 1'b1;
    end else if (out_ack) begin
      out_valid   <= 1'b0;
    end
  end

  // NOTE: later non-blocking assignments win, so an error on the same edge as
  // a STATUS write leaves its sticky bit set.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_status) begin
        underflow <= 1'b0;
        overflow  <= 1'b0;
      end
      if (underflow_evt) underflow <= 1'b1;
      if (overflow_evt)  overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lime_io_port.sv
// Scoreboarded random and directed test of lime_io_port against a queue-based
// behavioural model of the port.
module tb_lime_io_port;

  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] rdata;
    logic        out_valid;
    logic [15:0] main_output;
    logic        ready;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [1:0]  io_addr;
  logic [15:0] io_wdata;
  logic        io_we;
  logic        io_re;
  logic [15:0] io_rdata;
  logic [15:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [15:0] main_output;
  logic        out_valid;
  logic        out_ack;

  lime_io_port #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .io_addr       (io_addr),
    .io_wdata      (io_wdata),
    .io_we         (io_we),
    .io_re         (io_re),
    .io_rdata      (io_rdata),
    .host_in_data  (host_in_data),
    .host_in_valid (host_in_valid),
    .host_in_ready (host_in_ready),
    .main_output   (main_output),
    .out_valid     (out_valid),
    .out_ack       (out_ack)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   driving_done = 1'b0;

  // Reference model state
  logic [15:0] m_fifo[$];
  logic        m_ov;
  logic [15:0] m_mo;
  logic        m_uf;
  logic        m_of;
  logic [15:0] m_rdata;

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the state visible after the edge.
  task automatic cycle(input logic rst, input logic [1:0] addr, input logic [15:0] wdata,
                       input logic we, input logic re, input logic hv,
                       input logic [15:0] hd, input logic ack);
    exp_t        e;
    logic [15:0] status;
    logic        uf_evt;
    logic        of_evt;
    logic        can_push;
    @(negedge CLK);
    Reset = rst; io_addr = addr; io_wdata = wdata; io_we = we; io_re = re;
    host_in_valid = hv; host_in_data = hd; out_ack = ack;

    if (rst) begin
      m_fifo.delete();
      m_ov = 1'b0; m_mo = 16'h0000; m_uf = 1'b0; m_of = 1'b0; m_rdata = 16'h0000;
    end else begin
      uf_evt   = 1'b0;
      of_evt   = 1'b0;
      can_push = (m_fifo.size() < DEPTH);
      status   = 16'h0000;
      status[0]   = (m_fifo.size() != 0);
      status[1]   = m_ov;
      status[6:2] = 5'(m_fifo.size());
      status[7]   = m_uf;
      status[8]   = m_of;
      if (re) begin
        if (addr == 2'd0) begin
          if (m_fifo.size() > 0) m_rdata = m_fifo.pop_front();
          else begin
            m_rdata = 16'h0000;
            uf_evt  = 1'b1;
          end
        end else if (addr == 2'd1) m_rdata = status;
        else m_rdata = 16'h0000;
      end
      if (hv && can_push) m_fifo.push_back(hd);
      if (we && addr == 2'd2) begin
        if (!m_ov || ack) begin
          m_mo = wdata;
          m_ov = 1'b1;
        end else of_evt = 1'b1;
      end else if (ack) m_ov = 1'b0;
      if (we && addr == 2'd1) begin
        m_uf = 1'b0;
        m_of = 1'b0;
      end
      if (uf_evt) m_uf = 1'b1;
      if (of_evt) m_of = 1'b1;
    end

    e.rdata       = m_rdata;
    e.out_valid   = m_ov;
    e.main_output = m_mo;
    e.ready       = !rst && (m_fifo.size() < DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b0, 2'd3, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask
  task automatic rd(input logic [1:0] a);
    cycle(1'b0, a, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic ack);
    cycle(1'b0, a, d, 1'b1, 1'b0, 1'b0, 16'h0, ack);
  endtask
  task automatic host(input logic [15:0] d);
    cycle(1'b0, 2'd3, 16'h0, 1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask
  task automatic do_reset();
    cycle(1'b1, 2'd3, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // Monitor: every edge the DUT presents a new state, compared against the
  // oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("io_rdata",      io_rdata,             e.rdata);
        check("out_valid",     16'(out_valid),       16'(e.out_valid));
        check("main_output",   main_output,          e.main_output);
        check("host_in_ready", 16'(host_in_ready),   16'(e.ready));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
    host_in_valid = 1'b0; host_in_data = '0; out_ack = 1'b0;
    m_ov = 1'b0; m_mo = '0; m_uf = 1'b0; m_of = 1'b0; m_rdata = '0;

    do_reset();
    do_reset();

    // Single word round trip
    host(16'h0006); idle(); rd(2'd0); rd(2'd1);

    // Fill, blocked push, drain, then underflow
    host(16'h1111); host(16'h2222); host(16'h3333); host(16'h4444);
    host(16'hDEAD); rd(2'd1);
    rd(2'd0); rd(2'd0); rd(2'd0); rd(2'd0); rd(2'd0); rd(2'd1);
    wr(2'd1, 16'hFFFF, 1'b0); rd(2'd1);

    // Output register and ack
    wr(2'd2, 16'h0005, 1'b0); idle();
    cycle(1'b0, 2'd3, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1); idle();

    // Overflow and sticky clear
    wr(2'd2, 16'h0005, 1'b0); wr(2'd2, 16'h0007, 1'b0); rd(2'd1);
    wr(2'd1, 16'h0000, 1'b0); rd(2'd1);

    // Write coincident with ack
    wr(2'd2, 16'h0009, 1'b1); rd(2'd1);
    cycle(1'b0, 2'd3, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 2'd3, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

    // Reserved address and simultaneous read/write/push/pop
    host(16'hA001); host(16'hA002);
    cycle(1'b0, 2'd3, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 2'd0, 16'h5555, 1'b1, 1'b1, 1'b1, 16'hA003, 1'b0);
    rd(2'd1);

    // Mid-operation reset with strobes asserted
    host(16'h0B01); host(16'h0B02); host(16'h0B03); wr(2'd2, 16'h00EE, 1'b0);
    cycle(1'b1, 2'd2, 16'h7777, 1'b1, 1'b1, 1'b1, 16'h0C00, 1'b0);
    idle(); rd(2'd1);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            2'($urandom_range(0, 3)),
            16'($urandom()),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0),
            16'($urandom()),
            ($urandom_range(0, 3) == 0));
    end

    idle();
    @(negedge CLK);
    @(negedge CLK);
    driving_done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lime_io_port.md
LIME_IO_PORT -- requirements
Module: lime_io_port

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets input FIFO entries; it SHALL be a power of two, range 2..16.
REQ-002 Port CLK  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Port Reset  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 Port io_addr  input  2  processor-side register select.
REQ-005 Port io_wdata  input  16  processor write data.
REQ-006 Port io_we  input  1  processor write strobe, one-cycle pulse per access.
REQ-007 Port io_re  input  1  processor read strobe, one-cycle pulse per access.
REQ-008 Port io_rdata  output  16  registered processor read data.
REQ-009 Port host_in_data  input  16  host word supplied to the processor.
REQ-010 Port host_in_valid  input  1  host word present.
REQ-011 Port host_in_ready  output  1  port can accept a host word.
REQ-012 Port main_output  output  16  word published by the processor to the host.
REQ-013 Port out_valid  output  1  main_output holds an unacknowledged word.
REQ-014 Port out_ack  input  1  host consumed main_output.

Function
REQ-015 Address map: 0 = DATA_IN (read pops FIFO), 1 = STATUS, 2 = DATA_OUT (write), 3 = reserved (read 0x0000, write ignored).
REQ-016 STATUS bits: [0] fifo non-empty, [1] out_valid, [6:2] fifo count, [7] underflow sticky, [8] overflow sticky, [15:9] zero.
REQ-017 Reads: io_rdata SHALL present the selected value on the cycle after io_re, and SHALL hold it until the next io_re.
REQ-018 Host push: a word SHALL be written into the FIFO on every edge where host_in_valid and host_in_ready are both high.
REQ-019 host_in_ready SHALL equal not-full combinationally; it SHALL be 0 while Reset is high.
REQ-020 Pop: io_re at address 0 with the FIFO non-empty SHALL return the oldest word and decrement count; order is strict FIFO.
REQ-021 Pop when empty: io_rdata SHALL be 0x0000, count unchanged, underflow sticky set.
REQ-022 Simultaneous push and pop (FIFO neither full nor empty): both SHALL occur; count unchanged.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated words.
REQ-024 Write to DATA_OUT with out_valid=0: main_output SHALL take io_wdata and out_valid SHALL rise on the next edge.
REQ-025 Write to DATA_OUT with out_valid=1 and out_ack=0: write SHALL be dropped, main_output unchanged, overflow sticky set.
REQ-026 out_ack high with out_valid=1 SHALL clear out_valid on that edge; main_output SHALL keep its last value.
REQ-027 DATA_OUT write and out_ack on the same edge: ack SHALL retire the old word, new word loaded, out_valid stays 1, no overflow.
REQ-028 out_ack with out_valid=0 SHALL have no effect.
REQ-029 Any write to STATUS SHALL clear both sticky bits; other STATUS bits are read-only.
REQ-030 io_we and io_re both high in one cycle: both SHALL be performed independently.

Reset
REQ-031 Reset SHALL clear FIFO pointers and count, out_valid=0, main_output=0x0000, io_rdata=0x0000, both sticky bits=0.
REQ-032 Reset asserted mid-operation SHALL discard FIFO contents and any pending output; strobes during Reset SHALL be ignored.
REQ-033 FIFO storage array need not be reset.

Structure
REQ-034 Shared package lime_io_pkg SHALL hold the address constants, STATUS bit positions and FIFO_DEPTH default.
REQ-035 The input FIFO SHALL be a sub-module lime_io_fifo (push/pop/full/empty/count); output register and decode stay in lime_io_port.

Verification
REQ-036 Push 0x0006 from host, processor reads addr 0 -> io_rdata=0x0006 one cycle after io_re, STATUS[0]=0 afterwards.
REQ-037 Push 4 words 0x1111..0x4444 -> host_in_ready=0, STATUS[6:2]=4; pop 4 -> same order, then pop -> 0x0000, STATUS[7]=1.
REQ-038 Write 0x0005 to addr 2 -> main_output=0x0005, out_valid=1 next cycle; out_ack pulse -> out_valid=0, main_output stays 0x0005.
REQ-039 Write 0x0005 then 0x0007 to addr 2 without ack -> main_output=0x0005, STATUS[8]=1; write addr 1 -> STATUS[8:7]=0.
REQ-040 Write 0x0009 to addr 2 on the same edge as out_ack -> main_output=0x0009, out_valid=1, STATUS[8]=0.
REQ-041 Fill FIFO with 3 words, pulse Reset -> count 0, host_in_ready=1 after release, out_valid=0, main_output=0x0000.
